// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through an IDLE/EXEC/RESP FSM.
// Ports: clk, rstn, req{0,1}_{valid,ready,a,b,op}, rsp{0,1}_{valid,ready},
//   rsp_c, rsp_zero, and grant_cnt{0,1} when ALU_ARB_PERF_EN is defined.

`ifndef ALU_ADD
`define ALU_ADD  5'd0
`define ALU_SUB  5'd1
`define ALU_AND  5'd2
`define ALU_OR   5'd3
`define ALU_XOR  5'd4
`define ALU_SLT  5'd5
`define ALU_SLTU 5'd6
`define ALU_SLL  5'd7
`define ALU_SRL  5'd8
`define ALU_SRA  5'd9
`endif

module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  op,
  output logic [31:0] c,
  output logic        zero
);

  always_comb begin
    c = a;
    case (op)
      `ALU_ADD:  c = a + b;
      `ALU_SUB:  c = a - b;
      `ALU_AND:  c = a & b;
      `ALU_OR:   c = a | b;
      `ALU_XOR:  c = a ^ b;
      `ALU_SLT:  c = {31'd0, $signed(a) < $signed(b)};
      `ALU_SLTU: c = {31'd0, a < b};
      `ALU_SLL:  c = a << b[4:0];
      `ALU_SRL:  c = a >> b[4:0];
      `ALU_SRA:  c = $signed(a) >>> b[4:0];
      default:   c = a;
    endcase
  end

  assign zero = (c == 32'd0);

endmodule

module alu_arbiter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_c,
  output logic        rsp_zero
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0] grant_cnt0,
  output logic [31:0] grant_cnt1
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        idx_q, idx_d;
  logic        en_q, en_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] c_q, c_d;
  logic        zero_q, zero_d;

  logic [31:0] alu_c;
  logic        alu_zero;
  logic        pick0;
  logic        rsp_take;

  alu u_alu (
    .a    (a_q),
    .b    (b_q),
    .op   (op_q),
    .c    (alu_c),
    .zero (alu_zero)
  );

  // Requester 0 wins when alone or when the pointer favours it.
  assign pick0    = req0_valid & (~req1_valid | ~ptr_q);
  assign rsp_take = idx_q ? rsp1_ready : rsp0_ready;

  // Grants are held off until the first clock edge after reset release.
  assign en_d = 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    c_d        = c_q;
    zero_d     = zero_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_q && (req0_valid || req1_valid)) begin
          req0_ready = pick0;
          req1_ready = ~pick0;
          idx_d      = ~pick0;
          a_d        = pick0 ? req0_a : req1_a;
          b_d        = pick0 ? req0_b : req1_b;
          op_d       = pick0 ? req0_op : req1_op;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        c_d     = alu_c;
        zero_d  = alu_zero;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_take) begin
          state_d = S_IDLE;
          ptr_d   = ~idx_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      idx_q   <= 1'b0;
      en_q    <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 5'd0;
      c_q     <= 32'd0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      c_q     <= c_d;
      zero_q  <= zero_d;
    end
  end

  assign rsp0_valid = (state_q == S_RESP) & ~idx_q;
  assign rsp1_valid = (state_q == S_RESP) & idx_q;
  assign rsp_c      = c_q;
  assign rsp_zero   = zero_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] cnt0_q, cnt0_d;
  logic [31:0] cnt1_q, cnt1_d;

  assign cnt0_d = cnt0_q + {31'd0, req0_ready};
  assign cnt1_d = cnt1_q + {31'd0, req1_ready};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt0_q <= 32'd0;
      cnt1_q <= 32'd0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter.
// Directed scenarios plus a randomized run against a transaction model.

`ifndef ALU_ADD
`define ALU_ADD  5'd0
`define ALU_SUB  5'd1
`define ALU_AND  5'd2
`define ALU_OR   5'd3
`define ALU_XOR  5'd4
`define ALU_SLT  5'd5
`define ALU_SLTU 5'd6
`define ALU_SLL  5'd7
`define ALU_SRL  5'd8
`define ALU_SRA  5'd9
`endif

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [4:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [4:0]  req1_op;
  logic        rsp0_valid, rsp0_ready;
  logic        rsp1_valid, rsp1_ready;
  logic [31:0] rsp_c;
  logic        rsp_zero;
`ifdef ALU_ARB_PERF_EN
  logic [31:0] grant_cnt0, grant_cnt1;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk        (clk),
    .rstn       (rstn),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_c      (rsp_c),
    .rsp_zero   (rsp_zero)
`ifdef ALU_ARB_PERF_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  function automatic logic [31:0] alu_ref(input logic [4:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      `ALU_ADD:  return a + b;
      `ALU_SUB:  return a - b;
      `ALU_AND:  return a & b;
      `ALU_OR:   return a | b;
      `ALU_XOR:  return a ^ b;
      `ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      `ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      `ALU_SLL:  return a << sh;
      `ALU_SRL:  return a >> sh;
      `ALU_SRA:  return $signed(a) >>> sh;
      default:   return a;
    endcase
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic apply_reset;
    idle_inputs();
    rstn = 0;
    step();
    step();
    rstn = 1;
    step();
  endtask

  task automatic test_reset;
    rstn = 0;
    req0_valid = 1; req1_valid = 1;
    req0_a = 5; req0_b = 7; req0_op = `ALU_ADD;
    req1_a = 1; req1_b = 2; req1_op = `ALU_ADD;
    rsp0_ready = 1; rsp1_ready = 1;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0 ||
        rsp_c !== 32'd0 || rsp_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b%b vld=%b%b c=%h z=%b want all 0",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_c, rsp_zero);
    end
    step();
    rstn = 1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_early_grant: got rdy=%b%b want 00",
               req0_ready, req1_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_grant: got rdy=%b%b want 10",
               req0_ready, req1_ready);
    end
  endtask

  task automatic test_basic;
    apply_reset();
    req0_valid = 1; req0_op = `ALU_ADD; req0_a = 5; req0_b = 7;
    rsp0_ready = 1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_accept: got rdy=%b%b want 10", req0_ready, req1_ready);
    end
    step();
    req0_valid = 0;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0 || rsp0_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_exec: got rdy0=%b vld0=%b want 0 0",
               req0_ready, rsp0_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 ||
        rsp_c !== 32'd12 || rsp_zero !== 1'b0) begin
      failures++;
      $display("FAIL basic_resp: got vld=%b%b c=%0d z=%b want 10 12 0",
               rsp0_valid, rsp1_valid, rsp_c, rsp_zero);
    end
    step();
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_release: got vld0=%b want 0", rsp0_valid);
    end
  endtask

  task automatic test_both;
    apply_reset();
    req0_valid = 1; req0_op = `ALU_SUB; req0_a = 3; req0_b = 3;
    req1_valid = 1; req1_op = `ALU_OR; req1_a = 32'hF0; req1_b = 32'h0F;
    rsp0_ready = 1; rsp1_ready = 1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL both_first_grant: got rdy=%b%b want 10",
               req0_ready, req1_ready);
    end
    step();
    req0_valid = 0;
    step();
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b1 || rsp_c !== 32'd0 || rsp_zero !== 1'b1) begin
      failures++;
      $display("FAIL both_rsp0: got vld0=%b c=%h z=%b want 1 0 1",
               rsp0_valid, rsp_c, rsp_zero);
    end
    step();
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      failures++;
      $display("FAIL both_second_grant: got rdy=%b%b want 01",
               req0_ready, req1_ready);
    end
    step();
    req1_valid = 0;
    step();
    @(negedge clk);
    checks++;
    if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 ||
        rsp_c !== 32'hFF || rsp_zero !== 1'b0) begin
      failures++;
      $display("FAIL both_rsp1: got vld=%b%b c=%h z=%b want 01 ff 0",
               rsp0_valid, rsp1_valid, rsp_c, rsp_zero);
    end
    step();
  endtask

  task automatic test_back_to_back;
    int gidx[$];
    int gcyc[$];
    apply_reset();
    req0_valid = 1; req1_valid = 1;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int cyc = 0; cyc < 40 && gidx.size() < 4; cyc++) begin
      req0_a = $urandom; req0_b = $urandom; req0_op = 5'($urandom_range(0, 15));
      req1_a = $urandom; req1_b = $urandom; req1_op = 5'($urandom_range(0, 15));
      @(negedge clk);
      if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
        checks++;
        failures++;
        $display("FAIL b2b_dual_ready: got rdy=11 want at most one");
      end
      if (req0_ready === 1'b1) begin gidx.push_back(0); gcyc.push_back(cyc); end
      else if (req1_ready === 1'b1) begin gidx.push_back(1); gcyc.push_back(cyc); end
      step();
    end
    checks++;
    if (gidx.size() != 4) begin
      failures++;
      $display("FAIL b2b_count: got %0d grants want 4", gidx.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gidx[i] != i % 2) begin
          failures++;
          $display("FAIL b2b_order[%0d]: got %0d want %0d", i, gidx[i], i % 2);
        end
        if (i > 0) begin
          checks++;
          if (gcyc[i] - gcyc[i-1] != 3) begin
            failures++;
            $display("FAIL b2b_spacing[%0d]: got %0d want 3",
                     i, gcyc[i] - gcyc[i-1]);
          end
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_stall;
    logic [31:0] exp_c;
    apply_reset();
    req1_valid = 1; req1_op = `ALU_AND;
    req1_a = $urandom; req1_b = $urandom;
    exp_c = alu_ref(`ALU_AND, req1_a, req1_b);
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_grant: got rdy1=%b want 1", req1_ready);
    end
    step();
    req1_valid = 0;
    step();
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1; req1_valid = 1;
      rsp0_ready = 1; rsp1_ready = 0;
      @(negedge clk);
      checks++;
      if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_c !== exp_c ||
          rsp_zero !== (exp_c == 0) || req0_ready !== 1'b0 ||
          req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got vld=%b%b c=%h rdy=%b%b want 01 %h 00",
                 i, rsp0_valid, rsp1_valid, rsp_c, req0_ready, req1_ready, exp_c);
      end
      step();
    end
    rsp1_ready = 1;
    step();
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_ptr_flip: got rdy=%b%b want 10",
               req0_ready, req1_ready);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_reset_mid;
    apply_reset();
    req0_valid = 1; req0_op = `ALU_ADD; req0_a = 1; req0_b = 1;
    rsp0_ready = 1;
    step();
    req0_valid = 0;
    step();
    step();
    req1_valid = 1; req1_op = `ALU_ADD; req1_a = 40; req1_b = 2;
    rsp1_ready = 1;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_grant1: got rdy=%b%b want 01", req0_ready, req1_ready);
    end
    step();
    req1_valid = 0;
    #2;
    rstn = 0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0 ||
        rsp_c !== 32'd0 || rsp_zero !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got rdy=%b%b vld=%b%b c=%h z=%b want 0",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_c, rsp_zero);
    end
    step();
    step();
    rstn = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_no_rsp[%0d]: got vld=%b%b want 00",
                 i, rsp0_valid, rsp1_valid);
      end
      step();
    end
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_ptr_reset: got rdy=%b%b want 10",
               req0_ready, req1_ready);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_random;
    int          ptr_m, busy, age, idx_m;
    logic [31:0] c_m;
    logic        e0, e1, v0, v1, tk;
    apply_reset();
    ptr_m = 0; busy = 0; age = 0; idx_m = 0; c_m = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_op = 5'($urandom_range(0, 15));
      req1_op = 5'($urandom_range(0, 15));
      req0_a = $urandom; req1_a = $urandom;
      req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
      req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
      rsp0_ready = $urandom_range(0, 1);
      rsp1_ready = $urandom_range(0, 1);
      @(negedge clk);
      e0 = !busy && req0_valid && (!req1_valid || ptr_m == 0);
      e1 = !busy && req1_valid && !e0;
      checks++;
      if (req0_ready !== e0 || req1_ready !== e1) begin
        failures++;
        $display("FAIL rand_grant[%0d]: got rdy=%b%b want %b%b",
                 cyc, req0_ready, req1_ready, e0, e1);
      end
      v0 = busy && age >= 2 && idx_m == 0;
      v1 = busy && age >= 2 && idx_m == 1;
      checks++;
      if (rsp0_valid !== v0 || rsp1_valid !== v1) begin
        failures++;
        $display("FAIL rand_rsp_valid[%0d]: got %b%b want %b%b",
                 cyc, rsp0_valid, rsp1_valid, v0, v1);
      end
      if (v0 || v1) begin
        checks++;
        if (rsp_c !== c_m || rsp_zero !== (c_m == 0)) begin
          failures++;
          $display("FAIL rand_result[%0d]: got c=%h z=%b want c=%h z=%b",
                   cyc, rsp_c, rsp_zero, c_m, (c_m == 0));
        end
      end
      if (busy) begin
        tk = idx_m ? rsp1_ready : rsp0_ready;
        if (age >= 2 && tk) begin
          busy = 0;
          ptr_m = 1 - idx_m;
        end else begin
          age++;
        end
      end else if (e0 || e1) begin
        busy = 1;
        age = 1;
        idx_m = e1 ? 1 : 0;
        c_m = e1 ? alu_ref(req1_op, req1_a, req1_b)
                 : alu_ref(req0_op, req0_a, req0_b);
      end
      step();
    end
    idle_inputs();
  endtask

`ifdef ALU_ARB_PERF_EN
  task automatic test_perf;
    apply_reset();
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 5; i++) begin
      req0_valid = (i < 3); req1_valid = (i >= 3);
      step();
      req0_valid = 0; req1_valid = 0;
      step();
      step();
    end
    @(negedge clk);
    checks++;
    if (grant_cnt0 !== 32'd3 || grant_cnt1 !== 32'd2) begin
      failures++;
      $display("FAIL perf_counts: got %0d/%0d want 3/2", grant_cnt0, grant_cnt1);
    end
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rstn = 0;
    test_reset();
    test_basic();
    test_both();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef ALU_ARB_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
